// File: rtl/beta_irq_ctl.sv
// beta_irq_ctl: memory-mapped interrupt controller for the 2-stage Beta core.
//   clk    core clock
//   reset  asynchronous active-low reset
//   src    raw interrupt sources (asynchronous to clk)
//   sel    I/O decode hit for this block
//   addr   register word index (ma[4:2])
//   we     write strobe
//   wdata  write data
//   rdata  registered read data, valid the cycle after the access
//   irq    registered interrupt request (level)
//   xadr   registered handler address {vbase[30:7], id, 3'b000}
module beta_irq_ctl #(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic [2:0]      addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic [30:0]     xadr
);

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] s, s_d, rise, clr;
    logic [NSRC-1:0] pending, pending_nx, enable, edge_sel, act;
    logic [23:0]     vbase;
    logic [3:0]      id;
    logic [31:0]     rd_val;
    logic            wr, unused_wdata;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign wr   = sel & we;
    assign clr  = (wr && addr == 3'd0) ? wdata[NSRC-1:0] : '0;
    assign act  = pending & enable;
    // Every wdata bit is folded here so partially used write data stays lint-clean.
    assign unused_wdata = ^wdata;

    // Edge sources: a rise in the same cycle as a W1C wins. Level sources track s.
    assign pending_nx = (edge_sel & (rise | (pending & ~clr))) | (~edge_sel & s);

    // Lowest set index wins: scan from the top so bit 0 is assigned last.
    always_comb begin
        id = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (act[i]) id = 4'(i);
    end

    assign rd_val = (addr == 3'd0) ? 32'(pending)  :
                    (addr == 3'd1) ? 32'(enable)   :
                    (addr == 3'd2) ? 32'(edge_sel) :
                    (addr == 3'd3) ? {|act, 27'd0, id} :
                    (addr == 3'd4) ? {1'b0, vbase, 7'd0} : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d      <= '0;
            pending  <= '0;
            enable   <= '0;
            edge_sel <= '0;
            vbase    <= '0;
            irq      <= 1'b0;
            xadr     <= '0;
            rdata    <= '0;
        end else begin
            sync_q[0] <= src;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d     <= s;
            pending <= pending_nx;
            if (wr && addr == 3'd1) enable   <= wdata[NSRC-1:0];
            if (wr && addr == 3'd2) edge_sel <= wdata[NSRC-1:0];
            if (wr && addr == 3'd4) vbase    <= wdata[30:7];
            irq <= |act;
            // xadr keeps the last vector while nothing is active.
            if (|act) xadr <= {vbase, id, 3'b000};
            rdata <= (sel && !we) ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_beta_irq_ctl.sv
// tb_beta_irq_ctl: directed self-checking bench for beta_irq_ctl.
module tb_beta_irq_ctl;

    localparam int NSRC = 8;
    localparam int SS   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src;
    logic            sel, we;
    logic [2:0]      addr;
    logic [31:0]     wdata, rdata;
    logic            irq;
    logic [30:0]     xadr;
    logic [31:0]     rd;
    int              n_chk = 0;
    int              n_pass = 0;

    beta_irq_ctl #(.NSRC(NSRC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .src(src), .sel(sel), .addr(addr),
        .we(we), .wdata(wdata), .rdata(rdata), .irq(irq), .xadr(xadr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        tick(1);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input logic [NSRC-1:0] p);
        src = p;
        tick(1);
        src = '0;
    endtask

    initial begin
        reset = 1'b0; src = '1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick(3);
        check("rst_irq", 32'(irq), 0);
        check("rst_xadr", 32'(xadr), 0);
        check("rst_rdata", rdata, 0);
        src = '0; reset = 1'b1;
        bus_read(3'd0, rd); check("rst_pending", rd, 0);
        bus_read(3'd1, rd); check("rst_enable", rd, 0);
        bus_read(3'd4, rd); check("rst_vbase", rd, 0);
        check("rst_irq_post", 32'(irq), 0);

        bus_write(3'd2, 32'h01);
        bus_write(3'd1, 32'h01);
        pulse(8'h01);
        tick(SS);
        check("lat_irq_early", 32'(irq), 0);
        tick(1);
        check("lat_irq", 32'(irq), 1);
        bus_read(3'd0, rd); check("src0_pending", rd, 32'h01);
        bus_write(3'd0, 32'h01);
        tick(1);
        check("src0_clr", 32'(irq), 0);

        bus_write(3'd2, 32'hFF);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1, rd); check("enable_width", rd, 32'hFF);
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_read(3'd4, rd); check("vbase_mask", rd, 32'h7FFF_FF80);
        bus_write(3'd4, 32'h0000_1000);
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, rd); check("addr5_zero", rd, 0);

        pulse(8'h20);
        tick(5);
        bus_read(3'd0, rd); check("src5_pending", rd, 32'h20);
        check("src5_irq", 32'(irq), 1);
        check("src5_xadr", 32'(xadr), 32'h1028);
        bus_write(3'd0, 32'h20);
        check("w1c_irq_hold", 32'(irq), 1);
        tick(1);
        check("w1c_irq_drop", 32'(irq), 0);
        check("xadr_hold", 32'(xadr), 32'h1028);

        pulse(8'h44);
        tick(5);
        check("prio_xadr", 32'(xadr), 32'h1010);
        bus_write(3'd1, 32'hFB);
        check("mask_xadr_hold", 32'(xadr), 32'h1010);
        tick(1);
        check("mask_xadr", 32'(xadr), 32'h1030);
        check("mask_irq", 32'(irq), 1);
        bus_read(3'd3, rd); check("active", rd, 32'h8000_0006);
        bus_read(3'd0, rd); check("no_read_clear", rd, 32'h44);
        bus_write(3'd0, 32'h44);
        bus_write(3'd1, 32'hFF);
        tick(2);
        check("prio_cleared", 32'(irq), 0);

        pulse(8'h08);
        tick(5);
        bus_read(3'd0, rd); check("col_pre", rd, 32'h08);
        src = 8'h08;
        tick(SS);
        bus_write(3'd0, 32'h08);
        src = '0;
        tick(1);
        bus_read(3'd0, rd); check("col_pending", rd, 32'h08);
        check("col_irq", 32'(irq), 1);
        bus_write(3'd0, 32'h08);
        bus_read(3'd0, rd); check("col_clr", rd, 0);

        bus_write(3'd2, 32'h00);
        bus_write(3'd1, 32'h02);
        src = 8'h02;
        tick(5);
        bus_read(3'd0, rd); check("lvl_pending", rd, 32'h02);
        check("lvl_xadr", 32'(xadr), 32'h1008);
        bus_write(3'd0, 32'h02);
        bus_read(3'd0, rd); check("lvl_w1c_noop", rd, 32'h02);
        src = '0;
        tick(SS + 1);
        check("lvl_irq_early", 32'(irq), 1);
        tick(1);
        check("lvl_irq_drop", 32'(irq), 0);
        bus_read(3'd0, rd); check("lvl_pending_drop", rd, 0);

        src = 8'h02;
        tick(5);
        sel = 1'b1; we = 1'b0; addr = 3'd1;
        tick(1);
        check("pre_rst_irq", 32'(irq), 1);
        check("pre_rst_rdata", rdata, 32'h02);
        #2 reset = 1'b0;
        #1;
        check("arst_irq", 32'(irq), 0);
        check("arst_xadr", 32'(xadr), 0);
        check("arst_rdata", rdata, 0);
        sel = 1'b0; src = '0;
        tick(1);
        #3 reset = 1'b1;
        tick(1);
        bus_read(3'd0, rd); check("post_pending", rd, 0);
        bus_read(3'd1, rd); check("post_enable", rd, 0);
        bus_read(3'd2, rd); check("post_edge", rd, 0);
        bus_read(3'd4, rd); check("post_vbase", rd, 0);
        check("post_irq", 32'(irq), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/beta_irq_ctl.md
Name: beta_irq_ctl

Overview:
Memory-mapped interrupt controller for the 2-stage Beta core. It collects up to 16 peripheral interrupt sources (flipper switches, ball sensors, timers) and drives the core's irq input and 31-bit xadr handler address. Sources are synchronised, edge- or level-qualified, masked and priority-encoded. The core accesses control registers through the I/O decode of its single synchronous memory port.

Parameters:
NSRC, 8, number of interrupt sources (1..16)
SYNC_STAGES, 2, synchroniser depth for src inputs (>=2)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous active-low reset (0 = in reset)
src  input  NSRC  raw interrupt sources, asynchronous to clk
sel  input  1  I/O decode hit for this block, qualified with the current memory address
addr  input  3  word index, ma[4:2]
we  input  1  write strobe (core mwe)
wdata  input  32  write data (core mdout)
rdata  output  32  read data, valid the cycle after the sel/addr cycle
irq  output  1  interrupt request to the core
xadr  output  31  handler address to the core

Behaviour:
- Reset (reset=0, async): all state, rdata, irq and xadr = 0; pending, enable, edge and synchroniser flops = 0; vbase = 0.
- Synchroniser: each src bit passes through SYNC_STAGES flops -> s. Edge detector keeps s_d (s delayed one clk). rise = s & ~s_d.
- Register map (addr):
  - 0 PENDING: R; write-1-to-clear on edge sources.
  - 1 ENABLE: RW.
  - 2 EDGE: RW; 1 = rising-edge source, 0 = level source.
  - 3 ACTIVE: R; bit31 = any active, [3:0] = current id.
  - 4 VBASE: RW; bits [30:7] significant, all other bits read 0.
  - 5..7: read 0, writes ignored.
  - Bits >= NSRC in PENDING, ENABLE and EDGE read 0.
- Pending update per bit i:
  - Edge source: pending <= rise | (pending & ~(clr_i)), where clr_i = sel & we & addr==0 & wdata[i]. A rise in the same cycle as a clear wins; pending stays 1.
  - Level source: pending <= s[i]; W1C has no effect.
  - Changing EDGE does not alter pending that cycle. Next cycle follows the new mode; an edge source sampled high with s_d high does not re-fire.
- Priority: act = pending & enable. id = lowest set index of act (bit 0 highest priority).
- Outputs, registered every cycle:
  - irq <= |act.
  - xadr <= {vbase[30:7], id[3:0], 3'b000}. Vectors are 8 bytes apart, so each slot holds 2 instructions.
  - When act = 0, xadr holds its last value.
  - Latency: src edge to irq = SYNC_STAGES + 2 clk (sync, pending, irq register).
- irq is level: it stays high until software clears pending or disables the source. The core ignores irq in supervisor mode, so no in-service stack is kept. Nesting is not supported.
- Register write latency: a write to ENABLE or PENDING affects irq on the 2nd clk edge after the write cycle, with no intermediate glitch.
- Reads: rdata <= register[addr] when sel & ~we, otherwise 0. rdata reflects state before any same-cycle write. Side-effect-free: reading never clears pending.
- Reset mid-operation: asynchronous clear of everything. Sources high at release are seen as rises only if edge mode is set afterwards and a new rise occurs. EDGE = 0 after reset, so no spurious edges.

Test Plan:
- Reset: hold reset=0 with src=8'hFF, release, read PENDING/ENABLE/VBASE -> all 0, irq=0, xadr=0. Then a 0->1 pulse on src[0], with EDGE=0x01 and ENABLE=0x01 written afterwards -> PENDING=0x01, irq=1 after SYNC_STAGES+2 clk.
- Edge capture and clear: EDGE=0xFF, ENABLE=0xFF, VBASE=0x00001000.
  - Pulse src[5] for 1 clk -> PENDING=0x20, irq=1, xadr=0x1028.
  - Write PENDING=0x20 -> irq=0 two clk later.
- Priority and mask: pulse src[6] and src[2] together -> xadr=0x1010. Write ENABLE=0xFB -> xadr=0x1030 with irq staying 1. Read ACTIVE -> 0x80000006.
- Set/clear collision: src[3] rise lands in the same cycle as a write PENDING=0x08 -> PENDING stays 0x08, irq stays 1.
- Level source: EDGE=0x00, ENABLE=0x02, src[1]=1.
  - Write PENDING=0x02 -> PENDING still 0x02.
  - Drop src[1] -> PENDING=0 and irq=0 after SYNC_STAGES+2 clk.
- Async reset mid-operation: with irq=1, assert reset between clk edges -> irq, xadr and rdata go 0 immediately. All registers read reset values after release.
